// File: rtl/adder_tree_feeder_pkg.sv
// Shared geometry for the adder tree and its feeder: operand width, lane count,
// tree latency, count width and the lane-to-bit-offset helper.
package adder_tree_feeder_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_OPS  = 32;
    localparam int unsigned TREE_LAT = 5;
    localparam int unsigned CNT_W    = $clog2(NUM_OPS) + 1;
    localparam int unsigned IDX_W    = $clog2(NUM_OPS);

    function automatic int unsigned lane_offset(input int unsigned lane);
        return DATA_W * lane;
    endfunction

endpackage

// File: rtl/feeder_valid_delay.sv
// Fixed-depth shift register that carries {valid, count} alongside the adder
// tree, cleared synchronously so in-flight sets are dropped on reset.
module feeder_valid_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand assembler for the 32-operand adder tree, with a
// latency-matched valid/count side channel for the sum consumer.
module adder_tree_feeder
    import adder_tree_feeder_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic                      out_valid,
    output logic [CNT_W-1:0]          out_count,
    output logic                      sum_valid,
    output logic [CNT_W-1:0]          sum_count
);

    logic [DATA_W-1:0]         fill_buf [NUM_OPS];
    logic [IDX_W-1:0]          idx;
    logic                      accept;
    logic                      close_set;
    logic [NUM_OPS*DATA_W-1:0] set_next;
    logic [CNT_W:0]            delay_q;

    assign accept    = in_valid & in_ready;
    assign close_set = accept & (in_last | (idx == IDX_W'(NUM_OPS - 1)));

    // The closing word bypasses the buffer so the set leaves on the same edge.
    always_comb begin
        set_next = '0;
        for (int unsigned j = 0; j < NUM_OPS; j++) begin
            if (j < 32'(idx)) begin
                set_next[lane_offset(j) +: DATA_W] = fill_buf[j];
            end else if (j == 32'(idx)) begin
                set_next[lane_offset(j) +: DATA_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b0;
            idx       <= '0;
            out_ops   <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            for (int unsigned j = 0; j < NUM_OPS; j++) begin
                fill_buf[j] <= '0;
            end
        end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            if (accept) begin
                fill_buf[idx] <= in_data;
                if (close_set) begin
                    out_ops   <= set_next;
                    out_count <= CNT_W'(idx) + CNT_W'(1);
                    out_valid <= 1'b1;
                    idx       <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    feeder_valid_delay #(
        .WIDTH (CNT_W + 1),
        .DEPTH (TREE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({out_valid, out_count}),
        .q     (delay_q)
    );

    assign {sum_valid, sum_count} = delay_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder with a behavioural 5-deep adder tree
// standing in for the real tree on out_ops.
module tb_adder_tree_feeder;
    import adder_tree_feeder_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [DATA_W-1:0]         in_data = '0;
    logic                      in_valid = 1'b0;
    logic                      in_last = 1'b0;
    logic                      in_ready;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic                      out_valid;
    logic [CNT_W-1:0]          out_count;
    logic                      sum_valid;
    logic [CNT_W-1:0]          sum_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DATA_W+4:0] tree_pipe [TREE_LAT];
    logic [DATA_W+4:0] tree_sum;

    int                        cq[$];
    int                        oq_cyc[$];
    int                        oq_cnt[$];
    logic [NUM_OPS*DATA_W-1:0] oq_ops[$];
    int                        sq_cyc[$];
    int                        sq_cnt[$];
    logic [DATA_W+4:0]         sq_sum[$];

    adder_tree_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ops   (out_ops),
        .out_valid (out_valid),
        .out_count (out_count),
        .sum_valid (sum_valid),
        .sum_count (sum_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] lane(input logic [NUM_OPS*DATA_W-1:0] ops, input int unsigned i);
        return ops[lane_offset(i) +: DATA_W];
    endfunction

    function automatic logic [DATA_W+4:0] lane_sum(input logic [NUM_OPS*DATA_W-1:0] ops);
        logic [DATA_W+4:0] s = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) s += (DATA_W+5)'(lane(ops, i));
        return s;
    endfunction

    // Behavioural tree: full sum appears TREE_LAT edges after out_ops changes.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(TREE_LAT); k++) tree_pipe[k] <= '0;
        end else begin
            tree_pipe[0] <= lane_sum(out_ops);
            for (int k = 1; k < int'(TREE_LAT); k++) tree_pipe[k] <= tree_pipe[k-1];
        end
    end
    assign tree_sum = tree_pipe[TREE_LAT-1];

    always @(negedge clk) begin
        if (out_valid) begin
            oq_cyc.push_back(cyc);
            oq_cnt.push_back(int'(out_count));
            oq_ops.push_back(out_ops);
        end
        if (sum_valid) begin
            sq_cyc.push_back(cyc);
            sq_cnt.push_back(int'(sum_count));
            sq_sum.push_back(tree_sum);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last, input bit closes);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            idle(1);
            guard++;
        end
        if (!in_ready) check("in_ready wait", 64'(in_ready), 64'd1);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        idle(1);
        if (closes) cq.push_back(cyc);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Pops one closed set from every queue and checks count, sum and timing.
    task automatic expect_set(input string tag, input int cnt, input logic [DATA_W+4:0] sum,
                              output logic [NUM_OPS*DATA_W-1:0] ops);
        int cc;
        ops = '0;
        cc  = (cq.size() > 0) ? cq.pop_front() : -1000;
        if (oq_cnt.size() == 0) begin
            check({tag, " out_valid seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, " out_count"}, 64'(oq_cnt.pop_front()), 64'(cnt));
            check({tag, " out_valid cycle"}, 64'(oq_cyc.pop_front()), 64'(cc));
            ops = oq_ops.pop_front();
        end
        if (sq_cnt.size() == 0) begin
            check({tag, " sum_valid seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, " sum_count"}, 64'(sq_cnt.pop_front()), 64'(cnt));
            check({tag, " tree sum"}, 64'(sq_sum.pop_front()), 64'(sum));
            check({tag, " sum_valid cycle"}, 64'(sq_cyc.pop_front()), 64'(cc + int'(TREE_LAT)));
        end
    endtask

    initial begin
        logic [NUM_OPS*DATA_W-1:0] ops;
        int nz;

        idle(2);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_count", 64'(out_count), 64'd0);
        check("reset out_ops", 64'(out_ops != '0), 64'd0);
        check("reset sum_valid", 64'(sum_valid), 64'd0);
        check("reset sum_count", 64'(sum_count), 64'd0);
        reset = 1'b0;
        idle(1);
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        // Full 32-operand set, continuous valid.
        for (int i = 1; i <= 32; i++) send(DATA_W'(i), 1'b0, i == 32);
        idle(8);
        expect_set("full", 32, 37'd528, ops);
        check("full lane0", 64'(lane(ops, 0)), 64'd1);
        check("full lane31", 64'(lane(ops, 31)), 64'd32);
        check("full hold lane31", 64'(lane(out_ops, 31)), 64'd32);
        check("full hold out_valid", 64'(out_valid), 64'd0);

        // Short set closed by in_last, upper lanes zero-padded.
        send(32'd7, 1'b0, 1'b0);
        send(32'd8, 1'b0, 1'b0);
        send(32'd9, 1'b1, 1'b1);
        idle(8);
        expect_set("short", 3, 37'd24, ops);
        check("short lane0", 64'(lane(ops, 0)), 64'd7);
        check("short lane1", 64'(lane(ops, 1)), 64'd8);
        check("short lane2", 64'(lane(ops, 2)), 64'd9);
        nz = 0;
        for (int unsigned i = 3; i < NUM_OPS; i++) if (lane(ops, i) != '0) nz++;
        check("short nonzero upper lanes", 64'(nz), 64'd0);

        // All-ones operands: full-width sum with no truncation.
        for (int i = 0; i < 32; i++) send(32'hFFFF_FFFF, 1'b0, i == 31);
        idle(8);
        expect_set("ones", 32, 37'h1F_FFFF_FFE0, ops);

        // in_last on every word: back-to-back single-operand sets.
        send(32'd10, 1'b1, 1'b1);
        send(32'd20, 1'b1, 1'b1);
        send(32'd30, 1'b1, 1'b1);
        idle(8);
        expect_set("single a", 1, 37'd10, ops);
        check("single a lane0", 64'(lane(ops, 0)), 64'd10);
        expect_set("single b", 1, 37'd20, ops);
        check("single b lane0", 64'(lane(ops, 0)), 64'd20);
        expect_set("single c", 1, 37'd30, ops);
        check("single c lane0", 64'(lane(ops, 0)), 64'd30);

        // Partial set with gaps aborted by reset, then a fresh 4-word set.
        for (int i = 0; i < 20; i++) begin
            send(DATA_W'(100 + i), 1'b0, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) send(DATA_W'(i), i == 4, i == 4);
        idle(8);
        check("abort set count", 64'(oq_cnt.size()), 64'd1);
        check("abort sum count", 64'(sq_cnt.size()), 64'd1);
        expect_set("after abort", 4, 37'd10, ops);
        check("after abort lane3", 64'(lane(ops, 3)), 64'd4);
        check("after abort lane4", 64'(lane(ops, 4)), 64'd0);

        // Closed set still in the delay line when reset hits.
        send(32'd5, 1'b0, 1'b0);
        send(32'd6, 1'b1, 1'b1);
        idle(1);
        reset = 1'b1;
        idle(1);
        check("flight reset in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        idle(1);
        check("flight post in_ready", 64'(in_ready), 64'd1);
        idle(10);
        check("flight out_valid count", 64'(oq_cnt.size()), 64'd1);
        if (oq_cnt.size() > 0) check("flight out_count", 64'(oq_cnt.pop_front()), 64'd2);
        check("flight no sum_valid", 64'(sq_cnt.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Producer-side front end for the 5-stage, 32-operand adder tree.
- Accepts a serial stream of 32-bit operands over a valid/ready handshake and assembles them into one 32-lane operand set, zero-padding short sets.
- Presents each set on a flattened parallel bus that drives the tree's operand inputs.
- Runs a latency-matched valid/count pipeline, so the sum consumer knows which tree output cycle holds the sum of a real set and how many operands it contained.

Parameters:
- DATA_W, 32, operand width; must match the tree input width.
- NUM_OPS, 32, lanes per set; must match the tree operand count.
- TREE_LAT, 5, register stages from tree operand inputs to the tree's sum output.
- CNT_W, 6, width of operand count; equals clog2(NUM_OPS)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  DATA_W  serial operand.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualified by in_valid; closes the current set early.
- in_ready  out  1  feeder can accept in_data.
- out_ops  out  NUM_OPS*DATA_W  parallel operand set to the tree.
  - Lane i occupies bits [DATA_W*i+DATA_W-1 : DATA_W*i].
  - Lane 2k maps to tree input inp_k0; lane 2k+1 maps to inp_k1.
- out_valid  out  1  out_ops holds a newly assembled set this cycle.
- out_count  out  CNT_W  real operands in the presented set, 1..NUM_OPS.
- sum_valid  out  1  the tree's sum output this cycle belongs to a real set.
- sum_count  out  CNT_W  out_count of that set, delayed to match.

Behaviour:
- Reset is synchronous and active-high on clk. In the reset cycle and the following edge:
  - in_ready=0; out_ops=0; out_valid=0; out_count=0; sum_valid=0; sum_count=0.
  - Fill index cleared to 0; fill buffer cleared; entire valid/count delay line cleared.
- First cycle after reset deasserts: in_ready=1.
- in_ready stays 1 thereafter. The tree accepts one set per cycle and never stalls, so the feeder never backpressures. in_ready is still registered, and the source must honour it.
- Accept: in_valid & in_ready at a rising edge. The word is written to buffer lane idx, and idx increments.
- Set closes on an accept where idx==NUM_OPS-1 or in_last==1. On that same edge:
  - out_ops lane j <= buffered word for j<idx; <= in_data for j==idx; <= 0 for j>idx.
  - out_count <= idx+1; out_valid <= 1; idx <= 0.
- in_last at idx==NUM_OPS-1 is redundant; it closes exactly one set.
- in_last on the first word of a set closes a 1-operand set.
- out_valid is a single-cycle pulse per set. Back-to-back closes (e.g. in_last on every cycle) give out_valid high on consecutive cycles, each with new out_ops.
- out_ops and out_count hold their last values between sets. The tree keeps recomputing the held set, and sum_valid alone qualifies which sum cycles are new.
- Latency:
  - Close-accept at edge E → out_valid high in the cycle after E (call it cycle C).
  - sum_valid/sum_count high exactly TREE_LAT cycles later (cycle C+TREE_LAT), aligned with the tree's sum output for that set.
- Idle cycles (in_valid=0) leave idx and the buffer unchanged. Gaps inside a set are legal and do not affect assembly.
- Width: no arithmetic in the feeder. Operands pass unmodified; the tree widens to DATA_W+5 bits.
- Reset mid-set discards the partial set.
- Reset with sets in flight clears the delay line; no sum_valid is issued for those sets, and the tree's final sum register is also cleared by the shared reset.
- in_last with in_valid=0 is ignored. in_data is don't-care when in_valid=0.

Decomposition:
- Shared package holds DATA_W, NUM_OPS, TREE_LAT, CNT_W, and a lane-slice helper function (lane index → bit offset), shared with the tree and its testbench.
- One sub-module: feeder_valid_delay. TREE_LAT-deep shift register carrying {valid, count}, synchronously cleared by reset; instantiated with the width of CNT_W+1.

Test Plan:
- 32 words 1..32, in_valid continuous → out_valid one cycle after the 32nd accept; lane0=1, lane31=32; out_count=32. Five cycles later: sum_valid=1, sum_count=32, tree sum=528.
- Words 7,8,9 with in_last on 9 → lanes 0..2 = 7,8,9; lanes 3..31 = 0; out_count=3. sum_valid 5 cycles later with sum_count=3, tree sum=24.
- 32 words of 0xFFFFFFFF → tree sum = 0x1FFFFFFFE0 when sum_valid=1; no truncation.
- in_last on every cycle, values 10,20,30 → three consecutive out_valid pulses with out_count=1 and lane0=10,20,30. Three consecutive sum_valid pulses with sums 10,20,30.
- 20 words with random in_valid gaps, then reset for 1 cycle, then a 4-word in_last set 1,2,3,4 → no out_valid or sum_valid for the aborted set; next set gives out_count=4, sum=10.
- Set closed, then reset asserted 2 cycles later → sum_valid never asserts for that set; in_ready=0 during reset, 1 on the first cycle after.
